// File: rtl/fpu_share_arbiter_if.sv
// fpu_share_arbiter_if
//   Groups the requester-side and operator-side signals of fpu_share_arbiter.
//   Requester side : req_valid/req_ready/req_a/req_b (issue),
//                    resp_valid/resp_ready/resp_data (result return).
//   Operator side  : fu_a/fu_b/fu_t (registered issue), fu_out (result).
//   Wide buses are flattened, requester i at [i*DW +: DW].
//   Modports: slave  = the arbiter itself
//             master = requesters plus the operator (testbench / wrapper)
interface fpu_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*DW-1:0] req_a;
    logic [NUM_REQ*DW-1:0] req_b;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [NUM_REQ*DW-1:0] resp_data;
    logic [DW-1:0]         fu_a;
    logic [DW-1:0]         fu_b;
    logic                  fu_t;
    logic [DW-1:0]         fu_out;

    modport slave (
        input  req_valid, req_a, req_b, resp_ready, fu_out,
        output req_ready, resp_valid, resp_data, fu_a, fu_b, fu_t
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready, fu_out,
        input  req_ready, resp_valid, resp_data, fu_a, fu_b, fu_t
    );
endinterface

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter
//   Shares one fixed-latency pipelined f32 operator among NUM_REQ requesters.
//   Round-robin grant (at most one per cycle), registered issue to the
//   operator, a tag pipeline that follows each op through the operator, and a
//   held per-requester response register with valid/ready.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : fpu_share_arbiter_if.slave (requester + operator signals)
//   stat_issued, stat_stalled : only when FPU_ARB_STATS_EN is defined;
//                saturating 32-bit grant / stalled-cycle counters.
// Parameters: NUM_REQ (2..16), LATENCY (operator latency, 1..64), DW.
// Optional feature macro: FPU_ARB_STATS_EN
module fpu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 8,
    parameter int DW      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    fpu_share_arbiter_if.slave         bus
`ifdef FPU_ARB_STATS_EN
    ,
    output logic [31:0]                stat_issued,
    output logic [31:0]                stat_stalled
`endif
);
    localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][DW-1:0] req_a_arr, req_b_arr;
    assign req_a_arr = bus.req_a;
    assign req_b_arr = bus.req_b;

    logic [NUM_REQ-1:0]          busy_q, busy_d;
    logic [IDW-1:0]              rr_q, rr_d;
    logic [DW-1:0]               fu_a_q, fu_a_d, fu_b_q, fu_b_d;
    // Tag stage 0 is registered alongside fu_a/fu_b, so stage LATENCY lines
    // up with fu_out for that op.
    logic [LATENCY:0]            vld_pipe_q, vld_pipe_d;
    logic [LATENCY:0][IDW-1:0]   id_pipe_q, id_pipe_d;
    logic [NUM_REQ-1:0]          resp_valid_q, resp_valid_d;
    logic [NUM_REQ-1:0][DW-1:0]  resp_data_q, resp_data_d;

    logic [NUM_REQ-1:0]          eligible, gnt_oh;
    logic                        gnt_vld;
    logic [IDW-1:0]              gnt_id;

    // Round-robin search starting at the pointer; held off during reset so
    // req_ready reads 0 while rst is asserted.
    always_comb begin
        int idx;
        idx      = 0;
        eligible = bus.req_valid & ~busy_q;
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        gnt_oh   = '0;
        if (!rst) begin
            for (int off = 0; off < NUM_REQ; off++) begin
                idx = int'(rr_q) + off;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!gnt_vld && eligible[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = IDW'(idx);
                end
            end
        end
        if (gnt_vld) gnt_oh[gnt_id] = 1'b1;
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) rr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;

        // The handshake itself clears busy, so the bit reads 0 the cycle after.
        busy_d = (busy_q | gnt_oh) & ~(resp_valid_q & bus.resp_ready);

        fu_a_d = gnt_vld ? req_a_arr[gnt_id] : fu_a_q;
        fu_b_d = gnt_vld ? req_b_arr[gnt_id] : fu_b_q;

        vld_pipe_d = {vld_pipe_q[LATENCY-1:0], gnt_vld};
        id_pipe_d  = {id_pipe_q[LATENCY-1:0], gnt_id};

        // Busy guarantees no capture lands on a still-pending response.
        resp_valid_d = resp_valid_q & ~bus.resp_ready;
        resp_data_d  = resp_data_q;
        if (vld_pipe_q[LATENCY]) begin
            resp_valid_d[id_pipe_q[LATENCY]] = 1'b1;
            resp_data_d[id_pipe_q[LATENCY]]  = bus.fu_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= '0;
            rr_q         <= '0;
            fu_a_q       <= '0;
            fu_b_q       <= '0;
            vld_pipe_q   <= '0;
            id_pipe_q    <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            busy_q       <= busy_d;
            rr_q         <= rr_d;
            fu_a_q       <= fu_a_d;
            fu_b_q       <= fu_b_d;
            vld_pipe_q   <= vld_pipe_d;
            id_pipe_q    <= id_pipe_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign bus.req_ready  = gnt_oh;
    assign bus.fu_a       = fu_a_q;
    assign bus.fu_b       = fu_b_q;
    assign bus.fu_t       = vld_pipe_q[0];   // issue pulse is tag stage 0
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

`ifdef FPU_ARB_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d, stat_stalled_q, stat_stalled_d;

    always_comb begin
        stat_issued_d  = stat_issued_q;
        stat_stalled_d = stat_stalled_q;
        if (gnt_vld && stat_issued_q != 32'hFFFF_FFFF)
            stat_issued_d = stat_issued_q + 32'd1;
        // Stalled: someone eligible was left waiting this cycle.
        if (|(eligible & ~gnt_oh) && !rst && stat_stalled_q != 32'hFFFF_FFFF)
            stat_stalled_d = stat_stalled_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_q  <= '0;
            stat_stalled_q <= '0;
        end else begin
            stat_issued_q  <= stat_issued_d;
            stat_stalled_q <= stat_stalled_d;
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_stalled = stat_stalled_q;
`endif
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb_fpu_share_arbiter
//   Directed bench for fpu_share_arbiter (NUM_REQ=4, LATENCY=8, DW=32).
//   The operator is a small positive-operand f32 adder model with an 8-stage
//   pipeline. A negedge monitor tracks outstanding ops per requester and checks
//   returned data against hand-computed sums.
module tb_fpu_share_arbiter;
    localparam int N = 4;
    localparam int L = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_share_arbiter_if #(.NUM_REQ(N), .DW(32)) bus ();

`ifdef FPU_ARB_STATS_EN
    logic [31:0] stat_issued, stat_stalled;
    fpu_share_arbiter #(.NUM_REQ(N), .LATENCY(L), .DW(32)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .stat_issued(stat_issued), .stat_stalled(stat_stalled));
`else
    fpu_share_arbiter #(.NUM_REQ(N), .LATENCY(L), .DW(32)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    // Per-requester operands and hand-computed sums:
    // 1+2=3, 2+2=4, 4+4=8, 1+1=2
    logic [31:0] A   [N] = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h3F800000};
    logic [31:0] B   [N] = '{32'h40000000, 32'h40000000, 32'h40800000, 32'h3F800000};
    logic [31:0] EXP [N] = '{32'h40400000, 32'h40800000, 32'h41000000, 32'h40000000};

    assign bus.req_a = {A[3], A[2], A[1], A[0]};
    assign bus.req_b = {B[3], B[2], B[1], B[0]};

    // Positive normal operands only; truncating.
    function automatic logic [31:0] f32_add(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, et;
        logic [24:0] ma, mb, mt;
        ea = a[30:23]; eb = b[30:23];
        ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]};
        if (eb > ea) begin
            et = ea; ea = eb; eb = et;
            mt = ma; ma = mb; mb = mt;
        end
        mb = mb >> (ea - eb);
        ma = ma + mb;
        if (ma[24]) begin
            ma = ma >> 1;
            ea = ea + 8'd1;
        end
        return {1'b0, ea, ma[22:0]};
    endfunction

    logic [31:0] fpipe [L];
    always @(posedge clk) begin
        fpipe[0] <= bus.fu_t ? f32_add(bus.fu_a, bus.fu_b) : 32'hDEADBEEF;
        for (int k = 1; k < L; k++) fpipe[k] <= fpipe[k-1];
    end
    assign bus.fu_out = fpipe[L-1];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: grant log, outstanding tracking, returned-data check.
    logic [N-1:0] outst = '0;
    int glog[$];
    int gcyc[$];
    int gcnt [N] = '{0, 0, 0, 0};

    always @(negedge clk) begin
        if (rst) begin
            outst = '0;
        end else begin
            chk("rdy_no_vld", 32'(bus.req_ready & ~bus.req_valid), 32'd0);
            chk("rdy_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
            for (int i = 0; i < N; i++) begin
                if (bus.resp_valid[i]) begin
                    chk("spurious_resp", 32'(outst[i]), 32'd1);
                    if (bus.resp_ready[i]) begin
                        chk("resp_data", bus.resp_data[i*32 +: 32], EXP[i]);
                        outst[i] = 1'b0;
                    end
                end
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    chk("regrant_busy", 32'(outst[i]), 32'd0);
                    outst[i] = 1'b1;
                    glog.push_back(i);
                    gcyc.push_back(cyc);
                    gcnt[i]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        glog.delete();
        gcyc.delete();
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.resp_ready = '1;
        repeat (L + 6) tick();
    endtask

    initial begin
        int g2, go, t;
        bus.req_valid  = '0;
        bus.resp_ready = '0;

        // Reset state (sampled while rst is held)
        tick();
        @(negedge clk);
        chk("rst_req_ready",  32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data0", bus.resp_data[31:0], 32'd0);
        chk("rst_resp_data3", bus.resp_data[127:96], 32'd0);
        chk("rst_fu_a", bus.fu_a, 32'd0);
        chk("rst_fu_b", bus.fu_b, 32'd0);
        chk("rst_fu_t", 32'(bus.fu_t), 32'd0);
        tick();
        rst = 1'b0;

        // Single op: requester 0, 1.0 + 2.0
        tick();
        bus.req_valid = 4'b0001;              // cycle 0
        @(negedge clk);
        chk("single_ready", 32'(bus.req_ready), 32'd1);
        tick();                               // cycle 1
        bus.req_valid = '0;
        @(negedge clk);
        chk("single_fu_t", 32'(bus.fu_t), 32'd1);
        chk("single_fu_a", bus.fu_a, 32'h3F800000);
        chk("single_fu_b", bus.fu_b, 32'h40000000);
        tick();                               // cycle 2
        @(negedge clk);
        chk("single_fu_t_pulse", 32'(bus.fu_t), 32'd0);
        chk("single_fu_a_hold", bus.fu_a, 32'h3F800000);
        repeat (7) tick();                    // cycle 9
        @(negedge clk);
        chk("single_not_yet", 32'(bus.resp_valid), 32'd0);
        tick();                               // cycle 10
        @(negedge clk);
        chk("single_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("single_resp_data", bus.resp_data[31:0], 32'h40400000);
        tick();                               // cycle 11, still held
        @(negedge clk);
        chk("single_hold", 32'(bus.resp_valid), 32'd1);
        bus.resp_ready = 4'b0001;             // handshake in cycle 11
        tick();                               // cycle 12
        @(negedge clk);
        chk("single_cleared", 32'(bus.resp_valid), 32'd0);
        drain();

        // Round-robin: all requesting, all accepting
        do_reset();
        bus.resp_ready = '1;
        bus.req_valid  = '1;
        repeat (60) tick();
        chk("rr_nlog", 32'(glog.size() >= 8), 32'd1);
        if (glog.size() >= 8) begin
            for (int j = 0; j < 8; j++) chk("rr_order", 32'(glog[j]), 32'(j % 4));
            for (int j = 1; j < 4; j++) chk("rr_consec", 32'(gcyc[j] - gcyc[0]), 32'(j));
        end
        drain();

        // Backpressure on requester 2
        do_reset();
        bus.resp_ready = 4'b1011;
        bus.req_valid  = '1;
        t = 0;
        @(negedge clk);
        while (!bus.resp_valid[2] && t < 40) begin
            tick();
            @(negedge clk);
            t++;
        end
        chk("bp_wait", 32'(bus.resp_valid[2]), 32'd1);
        chk("bp_data", bus.resp_data[95:64], EXP[2]);
        g2 = gcnt[2];
        go = gcnt[0] + gcnt[1] + gcnt[3];
        for (int c = 0; c < 20; c++) begin
            tick();
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.resp_valid[2]), 32'd1);
            chk("bp_hold_data", bus.resp_data[95:64], EXP[2]);
        end
        chk("bp_no_regrant", 32'(gcnt[2] - g2), 32'd0);
        chk("bp_others_issue", 32'((gcnt[0] + gcnt[1] + gcnt[3] - go) >= 3), 32'd1);
        drain();

        // Fairness: only 1 and 3 active
        do_reset();
        bus.resp_ready = '1;
        bus.req_valid  = 4'b1010;
        t = 0;
        while (glog.size() < 50 && t < 1000) begin
            tick();
            t++;
        end
        chk("fair_count", 32'(glog.size() >= 50), 32'd1);
        if (glog.size() >= 50)
            for (int j = 0; j < 50; j++) chk("fair_alt", 32'(glog[j]), (j % 2 == 0) ? 32'd1 : 32'd3);
        drain();

        // Reset mid-flight
        do_reset();
        bus.resp_ready = '1;
        bus.req_valid  = 4'b0111;             // grants at cycles 0,1,2
        repeat (3) tick();
        bus.req_valid = '0;                   // cycle 3
        chk("mid_issued", 32'(glog.size()), 32'd3);
        repeat (3) tick();                    // cycle 6
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < L + 4; c++) begin
            @(negedge clk);
            chk("mid_no_capture", 32'(bus.resp_valid), 32'd0);
            tick();
        end
        bus.req_valid = 4'b1000;
        t = 0;
        @(negedge clk);
        while (!bus.req_ready[3] && t < 10) begin
            tick();
            @(negedge clk);
            t++;
        end
        chk("mid_regrant", 32'(bus.req_ready[3]), 32'd1);
        tick();
        bus.req_valid = '0;
        t = 0;
        @(negedge clk);
        while (!bus.resp_valid[3] && t < 20) begin
            tick();
            @(negedge clk);
            t++;
        end
        chk("mid_new_valid", 32'(bus.resp_valid), 32'h8);
        chk("mid_new_data", bus.resp_data[127:96], EXP[3]);
        drain();

`ifdef FPU_ARB_STATS_EN
        do_reset();
        bus.req_valid = '1;                   // cycle 0
        repeat (4) tick();
        bus.req_valid = '0;                   // cycle 4
        @(negedge clk);
        chk("stat_issued", stat_issued, 32'd4);
        chk("stat_stalled", stat_stalled, 32'd3);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
